// File: rtl/systolic_feed_scheduler.sv
// Feeds one 4x4 multiply into systolic_array: stores A/B, streams skewed rows/columns, waits for done.
// Optional run-cycle counter is built only when SYSTOLIC_PERF_CNT_EN is defined.
module systolic_feed_scheduler #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          arr_done,
  output logic          arr_rst,
  output logic [DW-1:0] inp_west0,
  output logic [DW-1:0] inp_west4,
  output logic [DW-1:0] inp_west8,
  output logic [DW-1:0] inp_west12,
  output logic [DW-1:0] inp_north0,
  output logic [DW-1:0] inp_north1,
  output logic [DW-1:0] inp_north2,
  output logic [DW-1:0] inp_north3,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   perf_cycles
);

  // state | meaning
  // IDLE  | accepts writes and start; array out of reset, streams zero
  // CLEAR | one-cycle array reset pulse, clears timeout
  // FEED  | t = 0..6, skewed operand streams
  // DRAIN | waits for arr_done, down-counter bounds the wait
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [2:0]      t_q, t_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_set;

  logic [DW-1:0]   a_q [16];
  logic [DW-1:0]   b_q [16];

  logic [DW-1:0]   west_q [4];
  logic [DW-1:0]   west_d [4];
  logic [DW-1:0]   north_q [4];
  logic [DW-1:0]   north_d [4];
  logic            arr_rst_q, arr_rst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic [2:0]      off_w, off_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (wr_en && (state_q == S_IDLE)) begin
      if (wr_sel) b_q[wr_addr] <= wr_data;
      else        a_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    to_set  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: begin
        if (t_q == 3'd6) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(TIMEOUT - 1);
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      // arr_done is checked first so it wins over the terminal count
      S_DRAIN: begin
        if (arr_done) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          to_set  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up with it
  always_comb begin
    arr_rst_d = (state_d == S_CLEAR);
    busy_d    = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    timeout_d = timeout_q;
    if (state_d == S_CLEAR) timeout_d = 1'b0;
    else if (to_set)        timeout_d = 1'b1;
    off_w = '0;
    off_n = '0;
    for (int i = 0; i < 4; i++) begin
      west_d[i]  = '0;
      north_d[i] = '0;
      if (state_d == S_FEED) begin
        off_w = t_d - 3'(i);
        if ((t_d >= 3'(i)) && (off_w <= 3'd3)) west_d[i] = a_q[{2'(i), off_w[1:0]}];
        off_n = t_d - 3'(i);
        if ((t_d >= 3'(i)) && (off_n <= 3'd3)) north_d[i] = b_q[{off_n[1:0], 2'(i)}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arr_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        west_q[k]  <= '0;
        north_q[k] <= '0;
      end
    end else begin
      arr_rst_q <= arr_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      for (int k = 0; k < 4; k++) begin
        west_q[k]  <= west_d[k];
        north_q[k] <= north_d[k];
      end
    end
  end

  assign arr_rst    = arr_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign inp_west0  = west_q[0];
  assign inp_west4  = west_q[1];
  assign inp_west8  = west_q[2];
  assign inp_west12 = west_q[3];
  assign inp_north0 = north_q[0];
  assign inp_north1 = north_q[1];
  assign inp_north2 = north_q[2];
  assign inp_north3 = north_q[3];

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                                  perf_q <= '0;
    else if ((state_q == S_IDLE) && start)    perf_q <= '0;
    else if (busy_q && (perf_q != 16'hFFFF))  perf_q <= perf_q + 16'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Bench for systolic_feed_scheduler: vector table for the canonical run, hand sequences for
// reset/timeout corners, randomized runs against a matrix-level reference model.
module tb_systolic_feed_scheduler;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, wr_sel, start, arr_done;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          arr_rst, busy, done, timeout;
  logic [DW-1:0] inp_west0, inp_west4, inp_west8, inp_west12;
  logic [DW-1:0] inp_north0, inp_north1, inp_north2, inp_north3;
  logic [15:0]   perf_cycles;

  systolic_feed_scheduler #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .arr_done(arr_done), .arr_rst(arr_rst),
    .inp_west0(inp_west0), .inp_west4(inp_west4), .inp_west8(inp_west8), .inp_west12(inp_west12),
    .inp_north0(inp_north0), .inp_north1(inp_north1), .inp_north2(inp_north2), .inp_north3(inp_north3),
    .busy(busy), .done(done), .timeout(timeout), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] w_act [4];
  logic [DW-1:0] n_act [4];
  assign w_act[0] = inp_west0;  assign w_act[1] = inp_west4;
  assign w_act[2] = inp_west8;  assign w_act[3] = inp_west12;
  assign n_act[0] = inp_north0; assign n_act[1] = inp_north1;
  assign n_act[2] = inp_north2; assign n_act[3] = inp_north3;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] ma [4][4];
  logic [DW-1:0] mb [4][4];
  logic [DW-1:0] cap_w [32][4];
  logic [DW-1:0] cap_n [32][4];
  bit            prev_to;

  typedef struct {
    int            c;
    logic [DW-1:0] w0, w12, n3;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int r, input int c, input logic [DW-1:0] v);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(r * 4 + c); wr_data = v;
    step();
    wr_en = 1'b0;
    if (sel) mb[r][c] = v;
    else     ma[r][c] = v;
  endtask

  // Feed step t: row i carries A[i][t-i], column j carries B[t-j][j], zero outside the window
  function automatic logic [DW-1:0] exp_w(input int i, input int t);
    if (t - i >= 0 && t - i <= 3) return ma[i][t - i];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_n(input int j, input int t);
    if (t - j >= 0 && t - j <= 3) return mb[t - j][j];
    return '0;
  endfunction

  // d = DRAIN cycle index (0-based) in which arr_done is raised; negative = never
  task automatic run(input int d, input bit interfere, input bit wr_first, input string tag);
    int            dc;
    bit            to_exp;
    logic [DW-1:0] v;
    int            pexp;
    if (d >= 0 && d < TIMEOUT) begin dc = 10 + d; to_exp = 1'b0; end
    else begin dc = 9 + TIMEOUT; to_exp = 1'b1; end
    chk($sformatf("%s timeout_before_start", tag), timeout, prev_to);
    start = 1'b1;
    if (wr_first) begin
      v = $urandom;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = v;
      ma[1][1] = v;
    end
    step();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= dc + 1; c++) begin
      chk($sformatf("%s arr_rst c%0d", tag, c), arr_rst, (c == 1));
      chk($sformatf("%s busy c%0d", tag, c), busy, (c < dc));
      chk($sformatf("%s done c%0d", tag, c), done, (c == dc));
      chk($sformatf("%s timeout c%0d", tag, c), timeout, (c >= dc) ? to_exp : 1'b0);
`ifdef SYSTOLIC_PERF_CNT_EN
      pexp = ((c < dc) ? c : dc) - 1;
`else
      pexp = 0;
`endif
      chk($sformatf("%s perf c%0d", tag, c), perf_cycles, pexp);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s west%0d c%0d", tag, i, c), w_act[i], exp_w(i, c - 2));
        chk($sformatf("%s north%0d c%0d", tag, i, c), n_act[i], exp_n(i, c - 2));
        cap_w[c][i] = w_act[i];
        cap_n[c][i] = n_act[i];
      end
      arr_done = ((d >= 0) && (c == 9 + d)) || (interfere && c == 5);
      start    = interfere && (c == 4);
      if (interfere && c == 9) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = $urandom;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    arr_done = 1'b0; start = 1'b0; wr_en = 1'b0;
    prev_to = to_exp;
  endtask

  // Rebuild C from the captured streams as the array would see them: PE(i,j) at step s
  // multiplies west row i delayed j hops with north column j delayed i hops.
  task automatic check_c(input string tag);
    logic [DW-1:0] acc, rexp;
    int            tw, tn;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0; rexp = '0;
        for (int s = 0; s <= 12; s++) begin
          tw = s - j; tn = s - i;
          if (tw >= 0 && tw <= 6 && tn >= 0 && tn <= 6) acc += cap_w[tw + 2][i] * cap_n[tn + 2][j];
        end
        for (int k = 0; k < 4; k++) rexp += ma[i][k] * mb[k][j];
        chk($sformatf("%s C[%0d][%0d]", tag, i, j), acc, rexp);
      end
    end
  endtask

  task automatic check_idle_reset(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s west%0d", tag, i), w_act[i], '0);
      chk($sformatf("%s north%0d", tag, i), n_act[i], '0);
    end
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " timeout"}, timeout, 1'b0);
    chk({tag, " arr_rst"}, arr_rst, 1'b1);
    chk({tag, " perf"}, perf_cycles, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a00;
    tbl[0] = '{2, 0,  0,  0};
    tbl[1] = '{3, 1,  0,  0};
    tbl[2] = '{4, 2,  0,  0};
    tbl[3] = '{5, 3, 12,  3};
    tbl[4] = '{6, 0, 13,  7};
    tbl[5] = '{7, 0, 14, 11};
    tbl[6] = '{8, 0, 15, 15};

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; arr_done = 1'b0; prev_to = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    step(); step();
    check_idle_reset("reset");
    rst = 1'b0;
    step();
    chk("idle arr_rst", arr_rst, 1'b0);
    chk("idle busy", busy, 1'b0);

    // A = B = row-major 0..15, arr_done in 2nd DRAIN cycle
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      load(1'b0, r, c, DW'(r * 4 + c));
      load(1'b1, r, c, DW'(r * 4 + c));
    end
    run(1, 1'b0, 1'b0, "seq");
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("tbl west0 c%0d", tbl[k].c), cap_w[tbl[k].c][0], tbl[k].w0);
      chk($sformatf("tbl west12 c%0d", tbl[k].c), cap_w[tbl[k].c][3], tbl[k].w12);
      chk($sformatf("tbl north3 c%0d", tbl[k].c), cap_n[tbl[k].c][3], tbl[k].n3);
    end
    check_c("seq");
    a00 = '0;
    for (int s = 0; s < 4; s++) a00 += cap_w[s + 2][0] * cap_n[s + 2][0];
    chk("seq C00 literal", a00, 56);

    // identity A: product must equal B, earliest done
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) load(1'b0, r, c, (r == c) ? 1 : 0);
    run(0, 1'b0, 1'b0, "ident");
    check_c("ident");

    run(2, 1'b1, 1'b0, "interfere");
    run(2, 1'b0, 1'b0, "rerun_perf");

    run(-1, 1'b0, 1'b0, "timeout");
    run(3, 1'b0, 1'b0, "after_timeout");
    run(TIMEOUT - 1, 1'b0, 1'b0, "done_at_boundary");
    run(TIMEOUT, 1'b0, 1'b0, "done_too_late");
    run(1, 1'b0, 1'b1, "start_with_write");

    // reset in the middle of FEED at t = 3
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    check_idle_reset("midfeed_rst");
    rst = 1'b0;
    step();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    prev_to = 1'b0;
    run(1, 1'b0, 1'b0, "post_rst_zero");
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      load(1'b0, r, c, $urandom_range(0, 1000));
      load(1'b1, r, c, $urandom_range(0, 1000));
    end
    run(0, 1'b0, 1'b0, "post_rst_load");
    check_c("post_rst_load");

    for (int it = 0; it < 20; it++) begin
      int d;
      for (int k = 0; k < 8; k++)
        load($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 2));
      run(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
      check_c($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_feed_scheduler.md
Name: systolic_feed_scheduler

Overview:
- Sequences one 4x4 matrix multiply on systolic_array.
- Holds operand matrices A and B, loaded through a word-write port.
- On start: pulses the array reset, then drives the skewed west/north operand streams the array expects. Row i and column j are delayed i and j cycles respectively, with zero padding.
- Then waits for the array's done, with a timeout, and reports completion.
- Sits between a host/DMA-side loader and the array instance.

Parameters:
- DW, 32, operand width; matches the array's 32-bit edge inputs.
- TIMEOUT, 16, maximum DRAIN cycles waiting for arr_done before timeout is flagged.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  operand write strobe.
- wr_sel  input  1  0 = matrix A, 1 = matrix B.
- wr_addr  input  4  element index = row*4 + col.
- wr_data  input  DW  element value.
- start  input  1  single-cycle request to run one multiply.
- arr_done  input  1  done from systolic_array.
- arr_rst  output  1  reset to systolic_array.
- inp_west0, inp_west4, inp_west8, inp_west12  output  DW each  row 0..3 streams to the array.
- inp_north0, inp_north1, inp_north2, inp_north3  output  DW each  column 0..3 streams to the array.
- busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  output  1  one-cycle pulse at end of run.
- timeout  output  1  sticky error flag; cleared by the next accepted start or by rst.
- perf_cycles  output  16  run cycle count (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge):
  - State -> IDLE.
  - A and B storage cleared to 0.
  - All stream outputs = 0; busy = 0; done = 0; timeout = 0; arr_rst = 1.
  - Reset overrides everything, including mid-run.
- Writes: accepted only in IDLE (wr_en=1 at edge). Writes in any other state are silently dropped.
- Start: honoured only in IDLE. start while busy is ignored. start and wr_en in the same IDLE cycle: the write lands first, start is accepted.
- All outputs are registered.
- States and transitions:
  - IDLE: arr_rst = 0, streams = 0. start -> CLEAR.
  - CLEAR (1 cycle): arr_rst = 1, streams = 0, busy = 1, timeout cleared. -> FEED with t = 0.
  - FEED (7 cycles, t = 0..6): arr_rst = 0. Feed counter t is 3 bits and increments each cycle.
    - West row i drives A[i][t-i] when 0 <= t-i <= 3, else 0.
    - North column j drives B[t-j][j] when 0 <= t-j <= 3, else 0.
    - t = 6 -> DRAIN.
  - DRAIN: streams = 0.
    - Drain counter increments each cycle.
    - arr_done = 1 -> DONE.
    - Counter reaches TIMEOUT with no arr_done -> set timeout, -> DONE.
    - arr_done and the timeout boundary in the same cycle: arr_done wins, timeout stays 0.
  - DONE (1 cycle): done = 1, busy = 0 in this cycle. -> IDLE.
- arr_done seen outside DRAIN is ignored.
- Latency: start accepted at edge k.
  - arr_rst high in cycle k+1.
  - First operands (A[0][0], B[0][0]) on inp_west0/inp_north0 in cycle k+2.
  - Last operands (A[3][3], B[3][3]) on inp_west12/inp_north3 in cycle k+8.
  - done at the earliest in cycle k+10.
- Stored matrices persist across runs. Rerunning start without writes repeats the same multiply.

Optional Feature:
- Macro: SYSTOLIC_PERF_CNT_EN.
- Defined:
  - perf_cycles clears on accepted start.
  - Increments every cycle busy is high, saturating at 16'hFFFF.
  - Holds its value after done until the next start. rst clears it.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Load A = B = row-major 0..15, pulse start, model arr_done 2 cycles after FEED ends -> feed streams exactly as specified:
  - inp_west0 = 0,1,2,3,0,0,0.
  - inp_west12 = 0,0,0,12,13,14,15.
  - inp_north3 = 0,0,0,3,7,11,15.
  - done pulses once; with the real array instance, C[0][0] = 56 (hierarchical peek).
- A = identity, B = 0..15, real array -> C = B. busy high from k+1 through k+9, then low.
- start asserted again during FEED and a wr_en to A[0] during DRAIN -> both ignored. A rerun reproduces the identical stream.
- arr_done held low -> timeout = 1 after TIMEOUT DRAIN cycles, done pulses. The next start clears timeout in CLEAR.
- rst asserted mid-FEED (t = 3) -> next cycle: all streams 0, busy 0, arr_rst 1, storage 0. A subsequent load/start runs normally.
- With SYSTOLIC_PERF_CNT_EN and arr_done arriving in the 3rd DRAIN cycle -> perf_cycles = 11 after done. Without the macro -> perf_cycles = 0 throughout.
